// File: rtl/dram_cmd_scheduler_if.sv
// dram_cmd_scheduler_if: bundles the two requester ports, the shared response
// bus, the temperature input and the DRAM command bus.
//   master : requester/DRAM-model side (drives requests, temp, DRAM read data)
//   slave  : scheduler side (drives ready/response, DRAM command bus, status)
interface dram_cmd_scheduler_if;
    logic        req0_valid;
    logic        req0_we;
    logic [9:0]  req0_row;
    logic [9:0]  req0_col;
    logic [30:0] req0_wdata;
    logic        req0_ready;
    logic        rsp0_valid;

    logic        req1_valid;
    logic        req1_we;
    logic [9:0]  req1_row;
    logic [9:0]  req1_col;
    logic [30:0] req1_wdata;
    logic        req1_ready;
    logic        rsp1_valid;

    logic [30:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [7:0]  temp;

    logic [1:0]  dram_opcode;
    logic [9:0]  dram_row;
    logic [9:0]  dram_column;
    logic [31:0] dram_data_in;
    logic [31:0] dram_data_out;
    logic [1:0]  dram_error;

    logic        ref_miss;
    logic        busy;

    modport master (
        output req0_valid, req0_we, req0_row, req0_col, req0_wdata,
        output req1_valid, req1_we, req1_row, req1_col, req1_wdata,
        output temp, dram_data_out, dram_error,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_rdata, rsp_err,
        input  dram_opcode, dram_row, dram_column, dram_data_in,
        input  ref_miss, busy
    );

    modport slave (
        input  req0_valid, req0_we, req0_row, req0_col, req0_wdata,
        input  req1_valid, req1_we, req1_row, req1_col, req1_wdata,
        input  temp, dram_data_out, dram_error,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_rdata, rsp_err,
        output dram_opcode, dram_row, dram_column, dram_data_in,
        output ref_miss, busy
    );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: two-port round-robin front end for a 1024x1024x32 DRAM.
// Keeps exactly one DRAM command in flight, adds bit-31 parity on writes,
// checks it on reads and inserts temperature-adaptive refresh commands.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of dram_cmd_scheduler_if (requests, responses, DRAM bus,
//           temp, ref_miss, busy)
module dram_cmd_scheduler #(
    parameter int unsigned REF_INTERVAL = 1000,
    parameter int unsigned TEMP_HOT     = 40,
    parameter int unsigned CMD_LAT      = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    dram_cmd_scheduler_if.slave bus
);

    localparam int unsigned     RefW    = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [RefW-1:0] LimCool = RefW'(REF_INTERVAL - 1);
    localparam logic [RefW-1:0] LimHot  = RefW'((REF_INTERVAL >> 1) - 1);
    localparam int unsigned     LatW    = (CMD_LAT > 2) ? $clog2(CMD_LAT) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(CMD_LAT - 1);
    localparam logic [7:0]      TempHot = 8'(TEMP_HOT);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StRefresh} state_e;

    state_e          state_q;
    logic [LatW-1:0] lat_q;
    logic            owner_q;
    logic            last_grant_q;
    logic            we_q;
    logic [1:0]      opcode_q;
    logic [9:0]      row_q;
    logic [9:0]      col_q;
    logic [31:0]     data_q;
    logic            rsp0_q;
    logic            rsp1_q;
    logic [30:0]     rdata_q;
    logic [1:0]      err_q;

    logic [RefW-1:0] ref_cnt_q;
    logic [RefW-1:0] ref_lim;
    logic            ref_due_q;
    logic            ref_miss_q;
    logic            ref_take;

    logic            grant0;
    logic            grant1;
    logic            sel_we;
    logic [9:0]      sel_row;
    logic [9:0]      sel_col;
    logic [30:0]     sel_wdata;

    logic            rd_bad;
    logic [30:0]     rdata_now;
    logic [1:0]      err_now;

    // ------------------------------------------------------------------------
    // Refresh timer. Compared against limit-1 so a hot->cool or cool->hot swap
    // takes effect immediately; a count already past the new limit fires next.
    // ------------------------------------------------------------------------
    assign ref_lim  = (bus.temp > TempHot) ? LimHot : LimCool;
    assign ref_take = (state_q == StIdle) && ref_due_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q  <= '0;
            ref_due_q  <= 1'b0;
            ref_miss_q <= 1'b0;
        end else if (ref_cnt_q >= ref_lim) begin
            ref_cnt_q <= '0;
            ref_due_q <= 1'b1;  // a fresh deadline wins over a same-cycle take
            if (ref_due_q) begin
                ref_miss_q <= 1'b1;
            end
        end else begin
            ref_cnt_q <= ref_cnt_q + RefW'(1);
            if (ref_take) begin
                ref_due_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration: only in IDLE and only when no refresh is owed.
    // ------------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !ref_due_q) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign sel_we    = grant1 ? bus.req1_we    : bus.req0_we;
    assign sel_row   = grant1 ? bus.req1_row   : bus.req0_row;
    assign sel_col   = grant1 ? bus.req1_col   : bus.req0_col;
    assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;

    // ------------------------------------------------------------------------
    // Response decode from the DRAM inputs as they stand during RESP.
    // ------------------------------------------------------------------------
    assign rd_bad = (bus.dram_error == 2'b01) ||
                    (bus.dram_data_out[31] != ^bus.dram_data_out[30:0]);

    always_comb begin
        rdata_now = rdata_q;
        err_now   = 2'b00;
        if (we_q) begin
            if (bus.dram_error == 2'b10) begin
                err_now = 2'b10;
            end
        end else begin
            rdata_now = bus.dram_data_out[30:0];
            if (rd_bad) begin
                err_now = 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command FSM.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            opcode_q     <= 2'b00;
            row_q        <= '0;
            col_q        <= '0;
            data_q       <= '0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 2'b00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ref_due_q) begin
                        state_q  <= StRefresh;
                        opcode_q <= 2'b11;
                        lat_q    <= '0;
                    end else if (grant0 || grant1) begin
                        state_q      <= StIssue;
                        owner_q      <= grant1;
                        last_grant_q <= grant1;
                        we_q         <= sel_we;
                        opcode_q     <= sel_we ? 2'b10 : 2'b01;
                        row_q        <= sel_row;
                        col_q        <= sel_col;
                        data_q       <= {^sel_wdata, sel_wdata};
                    end
                end
                StIssue: begin
                    state_q  <= StWait;
                    opcode_q <= 2'b00;
                    lat_q    <= LatW'(1);
                end
                StWait: begin
                    if (lat_q == LatLast) begin
                        state_q <= StResp;
                        rsp0_q  <= ~owner_q;
                        rsp1_q  <= owner_q;
                    end else begin
                        lat_q <= lat_q + LatW'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    rsp0_q  <= 1'b0;
                    rsp1_q  <= 1'b0;
                    rdata_q <= rdata_now;
                    err_q   <= err_now;
                end
                StRefresh: begin
                    opcode_q <= 2'b00;
                    if (lat_q == LatLast) begin
                        state_q <= StIdle;
                    end else begin
                        lat_q <= lat_q + LatW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.rsp0_valid   = rsp0_q;
    assign bus.rsp1_valid   = rsp1_q;
    // During RESP the payload comes straight from the DRAM inputs; afterwards
    // the captured copy holds it until the next RESP.
    assign bus.rsp_rdata    = (state_q == StResp) ? rdata_now : rdata_q;
    assign bus.rsp_err      = (state_q == StResp) ? err_now : err_q;
    assign bus.dram_opcode  = opcode_q;
    assign bus.dram_row     = row_q;
    assign bus.dram_column  = col_q;
    assign bus.dram_data_in = data_q;
    assign bus.ref_miss     = ref_miss_q;
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
module tb_dram_cmd_scheduler;

    localparam int unsigned CmdLat = 3;
    localparam int unsigned RefInt = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_m;

    always #5 clk = ~clk;

    dram_cmd_scheduler_if bus ();
    dram_cmd_scheduler_if bus_m ();

    dram_cmd_scheduler #(
        .REF_INTERVAL(RefInt),
        .TEMP_HOT    (40),
        .CMD_LAT     (CmdLat)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    dram_cmd_scheduler #(
        .REF_INTERVAL(4),
        .TEMP_HOT    (40),
        .CMD_LAT     (6)
    ) u_dut_miss (
        .clk  (clk),
        .rst_n(rst_n_m),
        .bus  (bus_m)
    );

    // Second instance: port 0 requests continuously, DRAM returns zeros.
    assign bus_m.req0_valid    = rst_n_m;
    assign bus_m.req0_we       = 1'b0;
    assign bus_m.req0_row      = 10'd0;
    assign bus_m.req0_col      = 10'd0;
    assign bus_m.req0_wdata    = 31'd0;
    assign bus_m.req1_valid    = 1'b0;
    assign bus_m.req1_we       = 1'b0;
    assign bus_m.req1_row      = 10'd0;
    assign bus_m.req1_col      = 10'd0;
    assign bus_m.req1_wdata    = 31'd0;
    assign bus_m.temp          = 8'd30;
    assign bus_m.dram_data_out = 32'd0;
    assign bus_m.dram_error    = 2'b00;

    // DRAM model for the main instance.
    logic [31:0] mem [logic [19:0]];
    logic [31:0] model_rdata = '0;
    logic        force_en    = 1'b0;
    logic [31:0] force_data  = '0;
    logic [1:0]  err_drv     = 2'b00;
    int          cyc         = 0;

    assign bus.dram_data_out = model_rdata;
    assign bus.dram_error    = err_drv;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dram_opcode == 2'b10) begin
            mem[{bus.dram_row, bus.dram_column}] = bus.dram_data_in;
        end else if (bus.dram_opcode == 2'b01) begin
            if (force_en) model_rdata <= force_data;
            else if (mem.exists({bus.dram_row, bus.dram_column}))
                model_rdata <= mem[{bus.dram_row, bus.dram_column}];
            else model_rdata <= '0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [30:0] wdata;
        logic        fen;
        logic [31:0] fdata;
        logic [1:0]  derr;
        logic [31:0] exp_din;
        logic [30:0] exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic we, input logic [9:0] r,
                                input logic [9:0] c, input logic [30:0] wd, input logic fen,
                                input logic [31:0] fd, input logic [1:0] de,
                                input logic [31:0] din, input logic [30:0] rd,
                                input logic [1:0] er);
        vec_t v;
        v.port = p; v.we = we; v.row = r; v.col = c; v.wdata = wd; v.fen = fen;
        v.fdata = fd; v.derr = de; v.exp_din = din; v.exp_rdata = rd; v.exp_err = er;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit seen;
        force_en   = v.fen;
        force_data = v.fdata;
        err_drv    = v.derr;
        if (v.port) begin
            bus.req1_we = v.we; bus.req1_row = v.row; bus.req1_col = v.col;
            bus.req1_wdata = v.wdata; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_we = v.we; bus.req0_row = v.row; bus.req0_col = v.col;
            bus.req0_wdata = v.wdata; bus.req0_valid = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (v.port ? bus.req1_ready : bus.req0_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("v%0d_ready_seen", idx), 32'(seen), 32'd1);
        if (!seen) begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            return;
        end
        check($sformatf("v%0d_other_ready", idx),
              32'(v.port ? bus.req0_ready : bus.req1_ready), 32'd0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check($sformatf("v%0d_opcode", idx), 32'(bus.dram_opcode), v.we ? 32'd2 : 32'd1);
        check($sformatf("v%0d_row", idx), 32'(bus.dram_row), 32'(v.row));
        check($sformatf("v%0d_col", idx), 32'(bus.dram_column), 32'(v.col));
        if (v.we) check($sformatf("v%0d_data_in", idx), bus.dram_data_in, v.exp_din);
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            #1;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check($sformatf("v%0d_rsp_seen", idx), 32'(seen), 32'd1);
        if (seen) begin
            check($sformatf("v%0d_latency", idx), 32'(lat), 32'(CmdLat + 1));
            check($sformatf("v%0d_owner", idx),
                  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, v.port ? 32'd2 : 32'd1);
            check($sformatf("v%0d_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
            if (!v.we) check($sformatf("v%0d_rdata", idx), 32'(bus.rsp_rdata), 32'(v.exp_rdata));
            @(negedge clk);
            #1;
            check($sformatf("v%0d_rsp_drop", idx),
                  32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
            check($sformatf("v%0d_err_hold", idx), 32'(bus.rsp_err), 32'(v.exp_err));
        end
        force_en = 1'b0;
        err_drv  = 2'b00;
    endtask

    task automatic wait_ref(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.dram_opcode == 2'b11) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_period(input logic [7:0] t8, input int exp, input string name);
        int  t0, t1;
        bit  ok0, ok1;
        bus.temp = t8;
        wait_ref(t0, ok0);
        wait_ref(t0, ok0);
        wait_ref(t1, ok1);
        check({name, "_found"}, 32'(ok0 & ok1), 32'd1);
        if (ok0 && ok1) check(name, 32'(t1 - t0), 32'(exp));
    endtask

    task automatic arb_test();
        int left0 = 4, left1 = 4, got = 0, rsps = 0, refs = 0, bad_ref = 0, both = 0;
        bit inflight = 1'b0;
        int order[$];
        bus.req0_we = 1'b1; bus.req0_row = 10'd20; bus.req0_col = 10'd1;
        bus.req0_wdata = 31'h11;
        bus.req1_we = 1'b1; bus.req1_row = 10'd21; bus.req1_col = 10'd2;
        bus.req1_wdata = 31'h22;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 300 && !(got == 8 && rsps == 8); c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both++;
            if (bus.req0_ready) begin order.push_back(0); left0--; got++; end
            if (bus.req1_ready) begin order.push_back(1); left1--; got++; end
            if (bus.dram_opcode == 2'b01 || bus.dram_opcode == 2'b10) inflight = 1'b1;
            if (bus.dram_opcode == 2'b11) begin
                refs++;
                if (inflight) bad_ref++;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                inflight = 1'b0;
                rsps++;
            end
            @(negedge clk);
            if (left0 <= 0) bus.req0_valid = 1'b0;
            if (left1 <= 0) bus.req1_valid = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("arb_grants", 32'(got), 32'd8);
        check("arb_responses", 32'(rsps), 32'd8);
        check("arb_dual_ready", 32'(both), 32'd0);
        check("arb_ref_mid_cmd", 32'(bad_ref), 32'd0);
        check("arb_ref_inserted", 32'(refs > 0), 32'd1);
        for (int i = 0; i < order.size() && i < 8; i++)
            check($sformatf("arb_order%0d", i), 32'(order[i]), 32'(i % 2));
    endtask

    vec_t vecs[11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        bit seen;
        vecs[0]  = mk(0, 1, 10'd5, 10'd7, 31'h3, 0, 0, 2'b00, 32'h0000_0003, 0, 2'b00);
        vecs[1]  = mk(0, 0, 10'd5, 10'd7, 0, 0, 0, 2'b00, 0, 31'h3, 2'b00);
        vecs[2]  = mk(1, 1, 10'd1, 10'd2, 31'h1, 0, 0, 2'b00, 32'h8000_0001, 0, 2'b00);
        vecs[3]  = mk(1, 0, 10'd1, 10'd2, 0, 0, 0, 2'b00, 0, 31'h1, 2'b00);
        vecs[4]  = mk(0, 0, 10'd9, 10'd9, 0, 1, 32'h8000_0000, 2'b00, 0, 31'h0, 2'b01);
        vecs[5]  = mk(0, 1, 10'd3, 10'd3, 31'h7FFF_FFFF, 0, 0, 2'b10, 32'hFFFF_FFFF, 0, 2'b10);
        vecs[6]  = mk(1, 0, 10'd3, 10'd3, 0, 0, 0, 2'b01, 0, 31'h7FFF_FFFF, 2'b01);
        vecs[7]  = mk(0, 0, 10'd3, 10'd3, 0, 0, 0, 2'b10, 0, 31'h7FFF_FFFF, 2'b00);
        vecs[8]  = mk(1, 1, 10'd1023, 10'd1023, 31'h5555_5555, 0, 0, 2'b01,
                      32'h5555_5555, 0, 2'b00);
        vecs[9]  = mk(1, 0, 10'd1023, 10'd1023, 0, 0, 0, 2'b00, 0, 31'h5555_5555, 2'b00);
        vecs[10] = mk(1, 0, 10'd8, 10'd8, 0, 1, 32'h0000_0001, 2'b00, 0, 31'h1, 2'b01);

        rst_n = 1'b0; rst_n_m = 1'b0;
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_row = 0; bus.req0_col = 0;
        bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_row = 0; bus.req1_col = 0;
        bus.req1_wdata = 0;
        bus.temp = 8'd30;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_opcode", 32'(bus.dram_opcode), 0);
        check("rst_data_in", bus.dram_data_in, 0);
        check("rst_rsp_err", 32'(bus.rsp_err), 0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        check("rst_ref_miss", 32'(bus.ref_miss), 0);
        check("rst_rsp_valid", 32'(bus.rsp0_valid | bus.rsp1_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst_n_m = 1'b1;
        #1;
        check("miss_after_release", 32'(bus_m.ref_miss), 0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        check("miss_set", 32'(bus_m.ref_miss), 1);

        arb_test();
        check("main_no_miss", 32'(bus.ref_miss), 0);
        check("miss_sticky", 32'(bus_m.ref_miss), 1);

        check_period(8'd30, RefInt, "ref_period_t30");
        check_period(8'd60, RefInt / 2, "ref_period_t60");
        check_period(8'd40, RefInt, "ref_period_t40");
        check_period(8'd41, RefInt / 2, "ref_period_t41");
        bus.temp = 8'd30;

        // Async reset while a read sits in WAIT.
        @(negedge clk);
        bus.req0_we = 1'b0; bus.req0_row = 10'd5; bus.req0_col = 10'd7;
        bus.req0_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req0_ready) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("arst_ready_seen", 32'(seen), 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_opcode", 32'(bus.dram_opcode), 0);
        check("arst_row", 32'(bus.dram_row), 0);
        check("arst_data_in", bus.dram_data_in, 0);
        check("arst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (bus.rsp0_valid || bus.rsp1_valid) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < CmdLat + 5; i++) begin
            #1;
            if (bus.rsp0_valid || bus.rsp1_valid) pulses++;
            @(negedge clk);
        end
        check("arst_no_rsp_pulse", 32'(pulses), 0);
        run_vec(99, vecs[1]);

        rst_n_m = 1'b0;
        #1;
        check("miss_cleared_by_reset", 32'(bus_m.ref_miss), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sits between two requesters (port 0, port 1) and the 1024x1024x32 DRAM model; drives its opcode/row/column/data_in bus.
- Round-robin arbitrates requests, generates the bit-31 parity on writes, and checks parity on reads.
- Runs a temperature-adaptive refresh timer and inserts refresh commands, which take priority over queued requests.
- Serialises all traffic so only one DRAM command is ever in flight.

Parameters:
- REF_INTERVAL, 1000: refresh period in cycles while temp <= TEMP_HOT.
- TEMP_HOT, 40: temperature threshold; above it the period is REF_INTERVAL>>1.
- CMD_LAT, 3: cycles waited after issue before sampling dram_data_out/dram_error; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid (N=0,1)  in  1  request pending; held until reqN_ready.
- reqN_we  in  1  1=write, 0=read.
- reqN_row  in  10  row address.
- reqN_col  in  10  column address.
- reqN_wdata  in  31  write payload, bits [30:0].
- reqN_ready  out  1  one-cycle accept pulse.
- rspN_valid  out  1  one-cycle completion pulse to the owning port.
- rsp_rdata  out  31  read payload; valid while rsp0_valid or rsp1_valid is high.
- rsp_err  out  2  00 ok, 01 read error, 10 write error.
- temp  in  8  die temperature.
- dram_opcode  out  2  00 nop, 01 read, 10 write, 11 refresh.
- dram_row  out  10  row address to the DRAM.
- dram_column  out  10  column address to the DRAM.
- dram_data_in  out  32  {^wdata, wdata}.
- dram_data_out  in  32  read data from the DRAM.
- dram_error  in  2  DRAM error code.
- ref_miss  out  1  sticky: a refresh came due while one was already pending.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-clean release): state IDLE; all outputs 0; refresh counter 0; ref_due 0; last_grant=1, so port 0 wins the first tie.
- Refresh timer:
  - Free-running counter increments every cycle.
  - Limit is REF_INTERVAL when temp <= TEMP_HOT, else REF_INTERVAL>>1; temp is sampled each cycle.
  - When counter >= limit-1: set ref_due, clear counter. If ref_due is already set at that point, also set ref_miss.
  - A drop of the limit below the current count fires on the next cycle.
- IDLE:
  - If ref_due: go to REFRESH. Refresh beats requests.
  - Otherwise, if one port is valid: grant it.
  - If both ports are valid: grant the port != last_grant.
  - On grant: pulse reqN_ready, latch we/row/col/wdata and owner, update last_grant, go to ISSUE.
- ISSUE (1 cycle):
  - dram_opcode = 01 or 10; row/column/data_in driven from the latch.
  - dram_data_in[31] = ^wdata[30:0].
  - Next state is WAIT.
- WAIT:
  - dram_opcode = 00; address and data held stable.
  - Lasts CMD_LAT-1 cycles, then goes to RESP.
- RESP (1 cycle): sample dram inputs, pulse rsp<owner>_valid.
  - Read: rsp_rdata = dram_data_out[30:0]. rsp_err = 01 if dram_error==01 or dram_data_out[31] != ^dram_data_out[30:0]; else 00.
  - Write: rsp_err = 10 if dram_error==10; else 00.
  - Next state is IDLE.
  - rsp_rdata and rsp_err hold their value until the next RESP.
- REFRESH:
  - 1 cycle with dram_opcode = 11.
  - Then CMD_LAT-1 cycles with dram_opcode = 00.
  - Clear ref_due on entry; return to IDLE.
  - A request arriving during REFRESH waits; ready is never given outside IDLE.
- Simultaneous events:
  - ref_due rising in the same cycle as a grant in IDLE: the grant proceeds; refresh runs next time IDLE is reached.
  - In-flight commands are never aborted.
- reqN_valid dropped before ready: treated as withdrawn, no error.
- Reset mid-operation: immediate return to IDLE with outputs 0. No response pulse is emitted for the aborted command.
- Back-to-back throughput: one command per CMD_LAT+2 cycles (IDLE + ISSUE + WAIT + RESP).

Test Plan:
- Single write then read (both on port 0):
  - Write row=5, col=7, wdata=31'h0000_0003 -> dram_data_in=32'h0000_0003 (parity 0), rsp_err=00.
  - Read of the same address -> rsp_rdata=31'h3, rsp_err=00, rsp0_valid CMD_LAT+1 cycles after ready.
- Arbitration: both ports valid continuously with 4 requests each -> ready order 0,1,0,1,0,1,0,1.
- Parity error: DRAM model returns 32'h8000_0000 on a read -> rsp_err=01. A write with dram_error=10 forced -> rsp_err=10.
- Refresh timing, REF_INTERVAL=16:
  - temp=30 -> opcode 11 every 16 cycles when idle.
  - temp=60 -> every 8 cycles.
  - Continuous requests -> refresh inserted between commands, never mid-command.
- ref_miss: REF_INTERVAL=4, CMD_LAT=6 with continuous traffic -> ref_miss set and stays set until rst_n low.
- Async reset in WAIT: rst_n low mid-cycle -> outputs 0 immediately, no rsp_valid pulse, first request after release is accepted normally.
